// File: rtl/wb_manager_pkg.sv
// Shared types and constants for the wb_manager Wishbone initiator.
package wb_manager_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_manager_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam logic [31:0] ERR_DATA               = 32'h0000_0000;

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle counter for wb_manager.
// Ports: clk/rst (sync, active-high), clr (zero the count), en (count one cycle),
// tc (count equals TIMEOUT_CYCLES; never asserted when TIMEOUT_CYCLES is 0).
module wb_timeout_counter #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  // Saturates rather than wrapping, so a disabled timeout never aliases.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (TIMEOUT_CYCLES != 0) && (count == TERM);

endmodule

// File: rtl/wb_manager.sv
// Wishbone classic initiator: one valid/ready request becomes one bus cycle,
// the result is returned on a valid/ready response channel, with a timeout.
// Ports: wb_clk_i/wb_rst_i (sync, active-high); req_* request channel;
// rsp_* response channel; wbm_* Wishbone master port; busy = not IDLE.
module wb_manager
  import wb_manager_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  wb_manager_state_t state, state_next;

  logic        cyc_next;
  logic        we_next;
  logic [3:0]  sel_next;
  logic [31:0] adr_next;
  logic [31:0] dat_next;
  logic        rsp_valid_next;
  logic [31:0] rsp_dat_next;
  logic        rsp_err_next;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_tc;

  wb_timeout_counter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  always_comb begin
    state_next     = state;
    cyc_next       = wbm_cyc_o;
    we_next        = wbm_we_o;
    sel_next       = wbm_sel_o;
    adr_next       = wbm_adr_o;
    dat_next       = wbm_dat_o;
    rsp_valid_next = rsp_valid;
    rsp_dat_next   = rsp_dat;
    rsp_err_next   = rsp_err;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          we_next    = req_we;
          sel_next   = req_sel;
          adr_next   = req_adr;
          dat_next   = req_dat;
          cyc_next   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        // ack takes priority over a timeout on the same edge.
        if (wbm_ack_i) begin
          cyc_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_dat_next   = wbm_we_o ? ERR_DATA : wbm_dat_i;
          rsp_err_next   = 1'b0;
          state_next     = RESP;
        end else if (cnt_tc) begin
          cyc_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_dat_next   = ERR_DATA;
          rsp_err_next   = 1'b1;
          state_next     = RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        cyc_next       = 1'b0;
        rsp_valid_next = 1'b0;
        state_next     = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      wbm_cyc_o <= cyc_next;
      wbm_we_o  <= we_next;
      wbm_sel_o <= sel_next;
      wbm_adr_o <= adr_next;
      wbm_dat_o <= dat_next;
      rsp_valid <= rsp_valid_next;
      rsp_dat   <= rsp_dat_next;
      rsp_err   <= rsp_err_next;
    end
  end

  assign wbm_stb_o = wbm_cyc_o;
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_wb_manager.sv
module tb_wb_manager;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic        ack;
  logic [31:0] dat_i;
  logic        busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  wb_manager #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_sel   (req_sel),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_sel_o (sel),
    .wbm_adr_o (adr),
    .wbm_dat_o (dat_o),
    .wbm_ack_i (ack),
    .wbm_dat_i (dat_i),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int unsigned ack_at;   // bus cycle on which the slave acks; 0 = never
    logic [31:0] sdat;
    int unsigned exp_cyc;
    logic [31:0] exp_dat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int unsigned bus_cycles;
    int unsigned k;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_sel   = v.sel;
    req_adr   = v.adr;
    req_dat   = v.dat;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_adr    = 32'hFFFF_FFFF;
    check("req_ready_bus", 32'(req_ready), 32'd0);
    check("busy_bus", 32'(busy), 32'd1);
    bus_cycles = 0;
    k = 1;
    while (cyc === 1'b1 && k <= 20) begin
      check("stb_eq_cyc", 32'(stb), 32'(cyc));
      check("field_we", 32'(we), 32'(v.we));
      check("field_sel", 32'(sel), 32'(v.sel));
      check("field_adr", adr, v.adr);
      check("field_dat", dat_o, v.dat);
      bus_cycles++;
      ack   = (k == v.ack_at);
      dat_i = v.sdat;
      @(posedge clk);
      @(negedge clk);
      ack   = 1'b0;
      dat_i = 32'hBAD0_BAD0;
      k++;
    end
    check("bus_cycles", bus_cycles, v.exp_cyc);
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_dat", rsp_dat, v.exp_dat);
    check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    check("stb_after", 32'(stb), 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_done", 32'(rsp_valid), 32'd0);
    check("req_ready_done", 32'(req_ready), 32'd1);
    check("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_5A5A, 3, 32'hDEAD_BEEF, 3, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 4'hF, 32'h3000_0000, 32'h0000_0000, 1, 32'h1234_5678, 1, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 4'hF, 32'h3000_0008, 32'h0000_0000, 0, 32'h7777_7777, 5, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 4'hC, 32'h3000_000C, 32'h0000_0000, 5, 32'hCAFE_F00D, 5, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b1, 4'h3, 32'h3000_0010, 32'h0BAD_CAFE, 0, 32'h1111_1111, 5, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b0, 4'h1, 32'h3000_0014, 32'h0000_0000, 2, 32'h0000_00FF, 2, 32'h0000_00FF, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_sel = '0; req_adr = '0; req_dat = '0;
    rsp_ready = 1'b0; ack = 1'b0; dat_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Stray ack in IDLE.
    @(negedge clk);
    ack = 1'b1; dat_i = 32'hFEED_FACE;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    check("stray_cyc", 32'(cyc), 32'd0);
    check("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    check("stray_req_ready", 32'(req_ready), 32'd1);

    // Response back-pressure with req_valid held high throughout.
    req_valid = 1'b1; req_we = 1'b0; req_sel = 4'hF; req_adr = 32'h3000_0020; req_dat = '0;
    @(posedge clk);
    @(negedge clk);
    req_adr = 32'h3000_0024;
    ack = 1'b1; dat_i = 32'h55AA_33CC;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0; dat_i = 32'h0;
    for (int i = 0; i < 10; i++) begin
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_dat", rsp_dat, 32'h55AA_33CC);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_cyc", 32'(cyc), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("b2b_req_ready", 32'(req_ready), 32'd1);
    check("b2b_cyc_gap", 32'(cyc), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_cyc", 32'(cyc), 32'd1);
    check("b2b_adr", adr, 32'h3000_0024);
    ack = 1'b1; dat_i = 32'h0000_0042;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    check("b2b_rsp_dat", rsp_dat, 32'h0000_0042);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during BUS, then a late ack.
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h3000_0030; req_dat = 32'h1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_cyc_before", 32'(cyc), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_cyc", 32'(cyc), 32'd0);
    check("mid_stb", 32'(stb), 32'd0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd1);
    ack = 1'b1; dat_i = 32'h9999_9999;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    check("late_ack_rsp_valid", 32'(rsp_valid), 32'd0);
    check("late_ack_cyc", 32'(cyc), 32'd0);
    check("late_ack_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_manager.md
# wb_manager

Wishbone classic initiator (manager) that converts a simple valid/ready request into a single Wishbone bus cycle and returns the result on a valid/ready response channel. It is the counterpart of the Wishbone slave ports exposed by `nebula_ii`. Typical uses are LA-driven bring-up, bench stimulus, or an on-chip sequencer that must access team designs, GPIO control or LA control through the same slave interface the caravel host uses. One outstanding transaction at a time, with a timeout so that a missing slave cannot hang the requester.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of bus cycles to wait for `ack` before the transaction is aborted; 0 disables the timeout.
- `CNT_W`, default 8: width of the timeout counter; must satisfy `TIMEOUT_CYCLES < 2**CNT_W`.

Ports:
- `wb_clk_i` in 1: the single clock; all logic is on the rising edge.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_sel` in 4: byte selects.
- `req_adr` in 32: byte address.
- `req_dat` in 32: write data.
- `rsp_valid` out 1: a response is held.
- `rsp_ready` in 1: the requester accepts the response.
- `rsp_dat` out 32: read data; 0 for writes and for errors.
- `rsp_err` out 1: the transaction timed out.
- `wbm_cyc_o`, `wbm_stb_o` out 1: Wishbone cycle and strobe; always equal to each other.
- `wbm_we_o` out 1, `wbm_sel_o` out 4, `wbm_adr_o` out 32, `wbm_dat_o` out 32: registered bus fields.
- `wbm_ack_i` in 1, `wbm_dat_i` in 32: slave acknowledge and read data.
- `busy` out 1: high in every state except IDLE.

## Operation
- The FSM has three states: IDLE, BUS, RESP. Reset forces IDLE.
- **IDLE:** `req_ready`=1. When `req_valid & req_ready` is sampled at an edge:
  - latch `we`, `sel`, `adr`, `dat` into the bus registers;
  - clear the counter;
  - move to BUS.
- **BUS:** `wbm_cyc_o` = `wbm_stb_o` = 1, and the bus fields are held stable. Each edge without `ack` increments the counter.
  - **`wbm_ack_i`=1 sampled:**
    - drop `cyc`/`stb` at that same edge;
    - `rsp_dat` takes `wbm_dat_i` if `we`=0, otherwise 0;
    - `rsp_err`=0;
    - move to RESP.
  - **Timeout** (the counter reaches `TIMEOUT_CYCLES`, `TIMEOUT_CYCLES`≠0, and no `ack`):
    - drop `cyc`/`stb`;
    - `rsp_dat`=0, `rsp_err`=1;
    - move to RESP.
  - **Simultaneous events:** if `ack` and timeout occur on the same edge, `ack` wins (`rsp_err`=0).
- **RESP:** `rsp_valid`=1, and `rsp_dat`/`rsp_err` are held until `rsp_ready`=1 is sampled. Then go to IDLE.
- **Back-to-back:** `req_ready` is 0 in RESP, so a new request is accepted no earlier than the cycle after the response handshake.
- **Ignored inputs:** `wbm_ack_i` is ignored in IDLE and RESP. `req_*` inputs are ignored outside IDLE.
- **Reset mid-operation:** return to IDLE at the reset edge, drop `cyc`/`stb` in the following cycle, and discard any pending response.
- **Reset values:** `wbm_cyc_o`=`wbm_stb_o`=`wbm_we_o`=0, `wbm_sel_o`=0, `wbm_adr_o`=0, `wbm_dat_o`=0, `rsp_valid`=0, `rsp_dat`=0, `rsp_err`=0, `busy`=0, `req_ready`=1.

## Timing
- Request accepted at edge N: `cyc`/`stb` are high from cycle N+1.
- `ack` sampled at edge M ≥ N+1: `cyc`/`stb` are low and `rsp_valid` is high from cycle M+1.
- Minimum latency (zero-wait slave) is request handshake to `rsp_valid` = 2 cycles, and the bus cycle lasts exactly 1 cycle.
- Timeout: `cyc` is high for exactly `TIMEOUT_CYCLES`+1 cycles, after which `rsp_err` is asserted.
- The block issues no pipelined or burst cycles, and `stb` is never deasserted while `cyc` is high.
- Throughput: at most one transaction per 3 cycles with `rsp_ready` tied high.
- All outputs are registered except `req_ready` and `busy`, which decode the state register.

## Structure
- Package `wb_manager_pkg` holds:
  - `wb_manager_state_t` (IDLE, BUS, RESP);
  - the default `TIMEOUT_CYCLES`;
  - the error data constant `32'h0000_0000`.
- One sub-module, `wb_timeout_counter` (clear, enable, terminal-count output, parameterised by `CNT_W`/`TIMEOUT_CYCLES`). Everything else is flat.

## Test plan
- Write `adr`=0x3000_0004, `dat`=0xA5A5_5A5A, `sel`=0xF; slave acks on the 3rd bus cycle.
  - Required: `cyc` high for 3 cycles with the fields stable, then `rsp_valid`=1, `rsp_err`=0, `rsp_dat`=0.
- Read `adr`=0x3000_0000; zero-wait slave returns 0x1234_5678.
  - Required: `cyc` high for 1 cycle, `rsp_dat`=0x1234_5678 exactly 2 cycles after the handshake.
- No slave, `TIMEOUT_CYCLES`=4.
  - Required: `cyc` high for 5 cycles, then `rsp_err`=1, `rsp_dat`=0, and the block returns to IDLE after `rsp_ready`.
- Hold `rsp_ready`=0 for 10 cycles with `req_valid` held high.
  - Required: `rsp_valid`/`rsp_dat` stable and `req_ready`=0 throughout; the second request is accepted the cycle after the response handshake.
- Assert `wb_rst_i` for 1 cycle during BUS.
  - Required: `cyc`/`stb` and `rsp_valid` are 0 after reset, a late `ack` produces no response, and `req_ready`=1.
- Pulse a stray `wbm_ack_i` in IDLE, and make `ack` coincide with the timeout edge.
  - Required: the stray `ack` has no effect; the coincident case gives `rsp_err`=0.
